ioctl_word_loader: RTL and testbench
====================================

// Module: ioctl_word_loader
// PURPOSE
//  Parametrised successor to the core's direct byte-wide ioctl hookup: packs hps_io download bytes into
//  DATA_W-bit words, routes them to one of NUM_TARGETS memories selected by ioctl_index, and buffers them
//  in a small FIFO with req/ack handshake to slow memories. Back-pressures hps_io via ioctl_wait.
//  Sits between hps_io and the cartridge/BIOS/RAM stores of the MP1000 system.
// PARAMETERS
//  DATA_W       16  output word width; multiple of 8, 8..64; LANES = DATA_W/8
//  ADDR_W       16  output word address width
//  NUM_TARGETS   4  number of memory targets; index values 0..NUM_TARGETS-1 valid
//  FIFO_DEPTH    4  word FIFO entries, power of 2, >=2
// PORTS
//  clk_sys         in   1            system clock; all logic on rising edge
//  reset_n         in   1            asynchronous active-low reset
//  ioctl_download  in   1            download active (hps_io)
//  ioctl_index     in   8            target select; [5:0] used, [7:6] must be 0
//  ioctl_wr        in   1            byte strobe, one cycle per byte
//  ioctl_addr      in   25           byte address within target
//  ioctl_dout      in   8            byte data
//  ioctl_wait      out  1            stall request to hps_io
//  mem_req         out  1            FIFO head valid
//  mem_ack         in   1            memory accepts head this cycle
//  mem_sel         out  NUM_TARGETS  one-hot target of head word
//  mem_addr        out  ADDR_W       word address of head
//  mem_data        out  DATA_W       word data, byte lane k = ioctl_addr%LANES==k (little-endian)
//  mem_be          out  LANES        byte enables of head word
//  busy            out  1            state != IDLE
//  done            out  1            one-cycle pulse at end of flush
//  checksum        out  8            mod-256 sum of accepted bytes, current/last download
//  overflow        out  1            sticky: byte dropped (bad index or address out of range)
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, FIFO empty, all outputs 0, packing register cleared.
//  States: IDLE -> LOAD on ioctl_download rise (clears checksum, overflow, packing reg; latches index).
//   LOAD -> FLUSH on ioctl_download fall; FLUSH -> DONE when partial word pushed and FIFO empty;
//   DONE -> IDLE next cycle, done=1 for exactly that DONE cycle.
//  Accept: ioctl_wr in LOAD, or in the cycle download falls (that byte is accepted before FLUSH).
//   Dropped (overflow<=1, no checksum update) if latched index>=NUM_TARGETS or
//   ioctl_addr/LANES >= 2**ADDR_W. Writes in IDLE/FLUSH/DONE ignored.
//  Packing: lane=ioctl_addr%LANES, word=ioctl_addr/LANES. Byte stored in lane, be bit set.
//   Word pushed to FIFO when (a) lane==LANES-1, or (b) a new byte's word differs from the pending word
//   (pending pushed first, new byte starts a fresh word, same cycle), or (c) in FLUSH if any be set.
//   Re-write of same lane before push overwrites data. Unwritten lanes: data 0, be 0.
//  DATA_W=8: every byte pushed immediately, mem_be=1'b1.
//  FIFO: push and pop same cycle allowed when full or empty-with-push-bypass not required (1-cycle
//   latency push->mem_req). Pop on mem_req&mem_ack. mem_* stable while mem_req=1 and mem_ack=0.
//  ioctl_wait = (fifo_count >= FIFO_DEPTH-1) | (state==FLUSH); registered, guaranteed headroom for the
//   in-flight byte. Push into full FIFO never occurs; assertion in bench.
//  checksum: 8-bit wrap-around add of every accepted byte, held after DONE until next download.
//  Download restart during FLUSH ignored until IDLE. Reset mid-download discards FIFO contents.
// TESTING
//  1 DATA_W=16, index 0, bytes 11,22,33,44 @addr 0..3, ack tied 1 -> words (0,2211,be11),(1,4433,be11); done 1 pulse; checksum AA.
//  2 3 bytes AA,BB,CC @0..2 then download falls -> words (0,BBAA,11),(1,00CC,01) ; done after flush.
//  3 mem_ack held 0 for 20 cycles, 16 bytes streamed honoring ioctl_wait -> no loss, FIFO never overflows, order kept.
//  4 index 5 with NUM_TARGETS=4, 4 bytes -> no mem_req, overflow=1, checksum 00; done still pulses.
//  5 addr jump 0,1 then 8 (DATA_W=16) -> word 0 pushed full, word 4 be 01; mem_sel=0001 throughout.
//  6 reset_n low mid-LOAD with 2 words queued -> outputs 0 async, mem_req 0, next download starts clean.

Source files
------------

// File: rtl/ioctl_word_loader_if.sv
// ioctl_word_loader_if: hps_io download side plus word-memory request side of the loader
interface ioctl_word_loader_if #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_TARGETS = 4
);
  localparam int LANES = DATA_W / 8;
  logic                   ioctl_download;
  logic [7:0]             ioctl_index;
  logic                   ioctl_wr;
  logic [24:0]            ioctl_addr;
  logic [7:0]             ioctl_dout;
  logic                   ioctl_wait;
  logic                   mem_req;
  logic                   mem_ack;
  logic [NUM_TARGETS-1:0] mem_sel;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  logic [LANES-1:0]       mem_be;
  logic                   busy;
  logic                   done;
  logic [7:0]             checksum;
  logic                   overflow;
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_req, mem_sel, mem_addr, mem_data, mem_be, busy, done, checksum, overflow
  );
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_req, mem_sel, mem_addr, mem_data, mem_be, busy, done, checksum, overflow
  );
endinterface

// File: rtl/ioctl_word_loader.sv
// ioctl_word_loader: packs hps_io download bytes into words and queues them to the selected memory
module ioctl_word_loader #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NUM_TARGETS = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input logic              clk_sys,
  input logic              reset_n,
  ioctl_word_loader_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = ADDR_W + DATA_W + LANES;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t            state_q, state_d;
  logic              dl_q;
  logic [7:0]        idx_q;
  logic [7:0]        sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] pdata_q, pdata_d, pd;
  logic [LANES-1:0]  pbe_q, pbe_d, pb;
  logic [ADDR_W-1:0] pword_q, pword_d;
  logic              full_q, full_d;
  logic [EW-1:0]     fifo_q [FIFO_DEPTH];
  logic [EW-1:0]     head;
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q;
  logic [LW-1:0]     lane;
  logic [24:0]       word_full;
  logic              start, acc, good, pend, pop, push, space, keep, req;
  assign word_full = 25'(bus.ioctl_addr / LANES);
  assign lane      = LW'(bus.ioctl_addr % LANES);
  assign start     = state_q == IDLE && bus.ioctl_download && !dl_q;
  assign acc       = state_q == LOAD && bus.ioctl_wr;
  assign good      = acc && 32'(idx_q) < NUM_TARGETS && (word_full >> ADDR_W) == '0;
  assign req       = cnt_q != '0;
  assign pop       = req && bus.mem_ack;
  assign pend      = |pbe_q;
  assign space     = cnt_q != (PW+1)'(FIFO_DEPTH) || pop;
  // a completed word leaves the packer the cycle after its last lane, so at most one push per cycle
  assign push      = pend && space && (full_q || state_q == FLUSH || (good && ADDR_W'(word_full) != pword_q));
  assign keep      = pend && !push;
  always_comb begin
    pd = keep ? pdata_q : '0;
    pb = keep ? pbe_q : '0;
    pd[lane*8 +: 8] = bus.ioctl_dout;
    pb[lane] = 1'b1;
    pdata_d = start ? '0 : good ? pd : push ? '0 : pdata_q;
    pbe_d   = start ? '0 : good ? pb : push ? '0 : pbe_q;
    pword_d = start ? '0 : good ? ADDR_W'(word_full) : pword_q;
    full_d  = start ? 1'b0 : good ? lane == LW'(LANES-1) : push ? 1'b0 : full_q;
    sum_d   = start ? '0 : good ? sum_q + bus.ioctl_dout : sum_q;
    ovf_d   = start ? 1'b0 : ovf_q | (acc && !good);
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start ? LOAD : IDLE) :
              state_q == LOAD  ? (bus.ioctl_download ? LOAD : FLUSH) :
              state_q == FLUSH ? (!pend && cnt_q == '0 ? DONE : FLUSH) : IDLE;
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      pdata_q <= '0;
      pbe_q   <= '0;
      pword_q <= '0;
      full_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dl_q    <= bus.ioctl_download;
      idx_q   <= start ? bus.ioctl_index : idx_q;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      pdata_q <= pdata_d;
      pbe_q   <= pbe_d;
      pword_q <= pword_d;
      full_q  <= full_d;
      wp_q    <= wp_q + PW'(push);
      rp_q    <= rp_q + PW'(pop);
      cnt_q   <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk_sys)
    if (push) fifo_q[wp_q] <= {pword_q, pdata_q, pbe_q};
  assign head         = fifo_q[rp_q];
  assign bus.mem_req  = req;
  assign bus.mem_addr = req ? head[EW-1 -: ADDR_W] : '0;
  assign bus.mem_data = req ? head[LANES +: DATA_W] : '0;
  assign bus.mem_be   = req ? head[LANES-1:0] : '0;
  assign bus.mem_sel  = req ? NUM_TARGETS'(1) << idx_q : '0;
  assign bus.checksum = sum_q;
  assign bus.overflow = ovf_q;
  always_comb begin
    bus.busy       = state_q != IDLE;
    bus.done       = state_q == DONE;
    bus.ioctl_wait = cnt_q >= (PW+1)'(FIFO_DEPTH-1) || state_q == FLUSH;
  end
endmodule

// File: tb/tb_ioctl_word_loader.sv
// tb_ioctl_word_loader: random and directed downloads scored against a byte-group model of the packer
module tb_ioctl_word_loader;
  localparam int DATA_W = 16, ADDR_W = 16, NT = 4, DEPTH = 4, LANES = 2;
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [3:0]  sel;
  } word_t;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  ioctl_word_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TARGETS(NT)) bus();
  ioctl_word_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_TARGETS(NT), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  int          checks = 0, errors = 0, done_cnt = 0, ack_mode = 1;
  word_t       exp_q[$], log_q[$], cur, hold_w;
  logic        cur_v = 1'b0, hold_v = 1'b0, exp_ovf = 1'b0;
  logic [7:0]  exp_sum = '0;
  logic [24:0] aq[$];
  logic [7:0]  dq[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic close_group();
    exp_q.push_back(cur);
    cur_v = 1'b0;
  endtask
  task automatic model_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    int w, l;
    w = int'(a) / LANES;
    l = int'(a) % LANES;
    if (int'(idx) >= NT || w >= 65536) begin
      exp_ovf = 1'b1;
      return;
    end
    exp_sum += d;
    if (cur_v && cur.addr != w[15:0]) close_group();
    if (!cur_v) begin
      cur = '0;
      cur.addr = w[15:0];
      cur.sel = 4'b1 << idx;
      cur_v = 1'b1;
    end
    cur.data[l*8 +: 8] = d;
    cur.be[l] = 1'b1;
    if (l == LANES-1) close_group();
  endtask
  task automatic put_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d, input bit fall);
    int g = 0;
    while (bus.ioctl_wait && g < 500) begin
      @(posedge clk_sys); #1;
      g++;
    end
    if (g >= 500) begin
      checks++; errors++;
      $display("FAIL wait_timeout: ioctl_wait stuck at %0b", bus.ioctl_wait);
    end
    bus.ioctl_wr = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (fall) bus.ioctl_download = 1'b0;
    model_byte(idx, a, d);
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
  endtask
  task automatic add(input logic [24:0] a, input logic [7:0] d);
    aq.push_back(a);
    dq.push_back(d);
  endtask
  task automatic run_dl(input logic [7:0] idx, input bit fall_last, input bit gaps);
    int g = 0;
    done_cnt = 0; log_q.delete(); exp_sum = '0; exp_ovf = 1'b0; cur_v = 1'b0;
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < aq.size(); i++) begin
      put_byte(idx, aq[i], dq[i], fall_last && i == aq.size()-1);
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk_sys); #1; end
    end
    bus.ioctl_download = 1'b0;
    if (cur_v) close_group();
    while (!bus.done && g < 2000) begin
      @(posedge clk_sys); #1;
      g++;
    end
    if (g >= 2000) begin
      checks++; errors++;
      $display("FAIL done_timeout: done never pulsed, busy=%0b", bus.busy);
    end
    repeat (3) begin @(posedge clk_sys); #1; end
    check("done_pulses", done_cnt, 1);
    aq.delete(); dq.delete();
  endtask
  initial forever begin
    @(posedge clk_sys); #1;
    bus.mem_ack = ack_mode == 2 ? 1'($urandom_range(0, 1)) : ack_mode == 1;
  end
  always @(negedge clk_sys) begin
    word_t w;
    if (reset_n) begin
      w = {bus.mem_addr, bus.mem_data, bus.mem_be, bus.mem_sel};
      if (hold_v) check("head_stable", {bus.mem_req, w}, {1'b1, hold_w});
      hold_v = bus.mem_req && !bus.mem_ack;
      hold_w = w;
      if (bus.mem_req && bus.mem_ack) begin
        log_q.push_back(w);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL word: got unexpected %h, none required", w);
        end else check("word", w, exp_q.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        check("checksum", bus.checksum, exp_sum);
        check("overflow", bus.overflow, exp_ovf);
        check("drained", exp_q.size(), 0);
      end
      if (dut.push && !dut.pop && dut.cnt_q == 3'(DEPTH)) begin
        checks++; errors++;
        $display("FAIL fifo_overrun: push into full FIFO, count %0d", dut.cnt_q);
      end
    end else hold_v = 1'b0;
  end
  initial begin
    bus.ioctl_download = 0; bus.ioctl_index = 0; bus.ioctl_wr = 0;
    bus.ioctl_addr = 0; bus.ioctl_dout = 0; bus.mem_ack = 0;
    #2 reset_n = 1'b0;
    #1 check("reset_outs", {bus.mem_req, bus.busy, bus.done, bus.overflow, bus.ioctl_wait, bus.checksum,
                            bus.mem_sel, bus.mem_be, bus.mem_data, bus.mem_addr}, 0);
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (2) begin @(posedge clk_sys); #1; end
    ack_mode = 1;
    add(0, 8'h11); add(1, 8'h22); add(2, 8'h33); add(3, 8'h44);
    run_dl(0, 0, 0);
    check("t1_count", log_q.size(), 2);
    check("t1_w0", log_q[0], {16'h0000, 16'h2211, 2'b11, 4'b0001});
    check("t1_w1", log_q[1], {16'h0001, 16'h4433, 2'b11, 4'b0001});
    check("t1_sum", bus.checksum, 8'hAA);
    add(0, 8'hAA); add(1, 8'hBB); add(2, 8'hCC);
    run_dl(0, 0, 0);
    check("t2_count", log_q.size(), 2);
    check("t2_w0", log_q[0], {16'h0000, 16'hBBAA, 2'b11, 4'b0001});
    check("t2_w1", log_q[1], {16'h0001, 16'h00CC, 2'b01, 4'b0001});
    fork
      begin
        ack_mode = 0;
        repeat (20) @(posedge clk_sys);
        ack_mode = 1;
      end
      begin
        for (int i = 0; i < 16; i++) add(25'(i), 8'(i));
        run_dl(0, 0, 0);
      end
    join
    check("t3_count", log_q.size(), 8);
    check("t3_last", log_q[7], {16'h0007, 16'h0F0E, 2'b11, 4'b0001});
    for (int i = 0; i < 4; i++) add(25'(i), 8'(8'h10 + i));
    run_dl(5, 0, 0);
    check("t4_count", log_q.size(), 0);
    check("t4_ovf", bus.overflow, 1);
    check("t4_sum", bus.checksum, 0);
    add(0, 8'h5A); add(1, 8'hA5); add(8, 8'h77);
    run_dl(0, 1, 0);
    check("t5_w0", log_q[0], {16'h0000, 16'hA55A, 2'b11, 4'b0001});
    check("t5_w1", log_q[1], {16'h0004, 16'h0077, 2'b01, 4'b0001});
    ack_mode = 0;
    bus.ioctl_index = 0;
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    for (int i = 0; i < 4; i++) put_byte(0, 25'(i), 8'(8'h60 + i), 0);
    repeat (3) begin @(posedge clk_sys); #1; end
    check("t6_queued", {bus.mem_req, bus.busy}, 2'b11);
    #2 reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    #1 check("t6_reset_outs", {bus.mem_req, bus.busy, bus.done, bus.overflow, bus.ioctl_wait, bus.checksum,
                               bus.mem_sel, bus.mem_be, bus.mem_data, bus.mem_addr}, 0);
    exp_q.delete(); cur_v = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    ack_mode = 1;
    add(4, 8'h01); add(5, 8'h02);
    run_dl(1, 0, 0);
    check("t6_clean", log_q.size(), 1);
    check("t6_w0", log_q[0], {16'h0002, 16'h0201, 2'b11, 4'b0010});
    ack_mode = 2;
    for (int k = 0; k < 10; k++) begin
      logic [24:0] a;
      logic [7:0] idx;
      int r;
      idx = $urandom_range(0, 9) == 0 ? 8'd5 : 8'($urandom_range(0, NT-1));
      a = 25'($urandom_range(0, 300));
      for (int i = 0; i < $urandom_range(6, 30); i++) begin
        add(a, 8'($urandom));
        r = $urandom_range(0, 19);
        a = r < 14 ? a + 25'd1 : r < 16 ? a : r < 18 ? 25'($urandom_range(0, 400)) : 25'h1FFFF00 + 25'($urandom_range(0, 255));
      end
      run_dl(idx, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
